// File: rtl/mic1_microsequencer.sv
// mic1_microsequencer: MIC-1 control-path sequencer with a hardware micro-call stack.
//
// Holds the microprogram counter and the latched ALU flags. Each unstalled rising edge
// it loads the next microaddress, chosen by JAMN/JAMZ/JMPC, call/return and the stack.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   stall             1 = hold every piece of state this cycle
//   N, Z              ALU flags; latched into N_q/Z_q on every unstalled edge
//   MBR               opcode byte, ORed into the low address bits when jmpc = 1
//   next_addr         MIR NEXT_ADDRESS field
//   jmpc, jamn, jamz  MIR multiway-branch controls
//   call, ret         push MPC+1 and branch / pop the stack into MPC
//   MPC               current microaddress
//   N_q, Z_q          latched flags
//   depth             number of occupied stack entries
//   stack_full/empty  decodes of depth
//   ovf, unf          sticky: call while full / ret while empty
module mic1_microsequencer #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned MBR_W       = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_ADDR  = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               stall,
   input  logic                               N,
   input  logic                               Z,
   input  logic [MBR_W-1:0]                   MBR,
   input  logic [ADDR_W-1:0]                  next_addr,
   input  logic                               jmpc,
   input  logic                               jamn,
   input  logic                               jamz,
   input  logic                               call,
   input  logic                               ret,
   output logic [ADDR_W-1:0]                  MPC,
   output logic                               N_q,
   output logic                               Z_q,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               ovf,
   output logic                               unf
);

   localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned PtrW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [DepthW-1:0] FullDepth = DepthW'(STACK_DEPTH);
   localparam logic [ADDR_W-1:0] ResetAddr = ADDR_W'(RESET_ADDR);

   logic [ADDR_W-1:0] mpc_q, mpc_d;
   logic              nflag_q, nflag_d;
   logic              zflag_q, zflag_d;
   logic [DepthW-1:0] depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push;

   // Stack storage needs no reset: depth gates every read, so stale entries are unreachable.
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

   logic              full;
   logic              empty;
   logic              high_bit;
   logic [ADDR_W-2:0] low;
   logic [ADDR_W-1:0] target;
   logic [DepthW-1:0] top_idx;
   logic [ADDR_W-1:0] top_entry;

   assign full  = (depth_q == FullDepth);
   assign empty = (depth_q == '0);

   // Branch decisions use the registered flags, giving the two-edge flag latency.
   assign high_bit = (jamz & zflag_q) | (jamn & nflag_q) | next_addr[ADDR_W-1];
   assign low      = next_addr[ADDR_W-2:0] | (jmpc ? (ADDR_W-1)'(MBR) : '0);
   assign target   = {high_bit, low};

   assign top_idx   = depth_q - 1'b1;
   assign top_entry = stack_q[top_idx[PtrW-1:0]];

   always_comb begin
      mpc_d   = mpc_q;
      nflag_d = nflag_q;
      zflag_d = zflag_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (!stall) begin
         nflag_d = N;
         zflag_d = Z;
         if (ret) begin
            // Return wins over call; a simultaneous call is dropped entirely.
            if (!empty) begin
               mpc_d   = top_entry;
               depth_d = depth_q - 1'b1;
            end else begin
               mpc_d = ResetAddr;
               unf_d = 1'b1;
            end
         end else if (call) begin
            mpc_d = target;
            if (!full) begin
               push    = 1'b1;
               depth_d = depth_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            mpc_d = target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mpc_q   <= ResetAddr;
         nflag_q <= 1'b0;
         zflag_q <= 1'b0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         mpc_q   <= mpc_d;
         nflag_q <= nflag_d;
         zflag_q <= zflag_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Return address wraps naturally at 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[depth_q[PtrW-1:0]] <= mpc_q + 1'b1;
      end
   end

   assign MPC         = mpc_q;
   assign N_q         = nflag_q;
   assign Z_q         = zflag_q;
   assign depth       = depth_q;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign ovf         = ovf_q;
   assign unf         = unf_q;

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Directed, table-driven bench for mic1_microsequencer (ADDR_W=9, MBR_W=8, STACK_DEPTH=4).
module tb_mic1_microsequencer;

   logic       clk;
   logic       rst;
   logic       stall;
   logic       N;
   logic       Z;
   logic [7:0] MBR;
   logic [8:0] next_addr;
   logic       jmpc;
   logic       jamn;
   logic       jamz;
   logic       call;
   logic       ret;
   logic [8:0] MPC;
   logic       N_q;
   logic       Z_q;
   logic [2:0] depth;
   logic       stack_full;
   logic       stack_empty;
   logic       ovf;
   logic       unf;

   int n_vec  = 0;
   int n_fail = 0;

   mic1_microsequencer #(
      .ADDR_W      (9),
      .MBR_W       (8),
      .STACK_DEPTH (4),
      .RESET_ADDR  (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .N           (N),
      .Z           (Z),
      .MBR         (MBR),
      .next_addr   (next_addr),
      .jmpc        (jmpc),
      .jamn        (jamn),
      .jamz        (jamz),
      .call        (call),
      .ret         (ret),
      .MPC         (MPC),
      .N_q         (N_q),
      .Z_q         (Z_q),
      .depth       (depth),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .ovf         (ovf),
      .unf         (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       n;
      logic       z;
      logic [7:0] mbr;
      logic [8:0] na;
      logic       jc;
      logic       jn;
      logic       jz;
      logic       ca;
      logic       re;
      logic [8:0] e_mpc;
      logic       e_n;
      logic       e_z;
      logic [2:0] e_depth;
      logic       e_ovf;
      logic       e_unf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic n, input logic z, input logic [7:0] mbr,
                      input logic [8:0] na, input logic jc, input logic jn, input logic jz,
                      input logic ca, input logic re, input logic [8:0] e_mpc,
                      input logic e_n, input logic e_z, input logic [2:0] e_depth,
                      input logic e_ovf, input logic e_unf);
      vec_t v;
      v.st = st; v.n = n; v.z = z; v.mbr = mbr; v.na = na;
      v.jc = jc; v.jn = jn; v.jz = jz; v.ca = ca; v.re = re;
      v.e_mpc = e_mpc; v.e_n = e_n; v.e_z = e_z; v.e_depth = e_depth;
      v.e_ovf = e_ovf; v.e_unf = e_unf;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic st, input logic n, input logic z, input logic [7:0] mbr,
                        input logic [8:0] na, input logic jc, input logic jn, input logic jz,
                        input logic ca, input logic re);
      stall = st; N = n; Z = z; MBR = mbr; next_addr = na;
      jmpc = jc; jamn = jn; jamz = jz; call = ca; ret = re;
   endtask

   task automatic check(input string name, input logic [8:0] e_mpc, input logic e_n,
                        input logic e_z, input logic [2:0] e_depth, input logic e_ovf,
                        input logic e_unf);
      logic e_full;
      logic e_empty;
      e_full  = (e_depth == 3'd4);
      e_empty = (e_depth == 3'd0);
      n_vec++;
      if (MPC !== e_mpc || N_q !== e_n || Z_q !== e_z || depth !== e_depth ||
          stack_full !== e_full || stack_empty !== e_empty || ovf !== e_ovf ||
          unf !== e_unf) begin
         n_fail++;
         $display("FAIL %s: got MPC=%h N_q=%b Z_q=%b depth=%0d full=%b empty=%b ovf=%b unf=%b ; want MPC=%h N_q=%b Z_q=%b depth=%0d full=%b empty=%b ovf=%b unf=%b",
                  name, MPC, N_q, Z_q, depth, stack_full, stack_empty, ovf, unf,
                  e_mpc, e_n, e_z, e_depth, e_full, e_empty, e_ovf, e_unf);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //   st n z mbr    na    jc jn jz ca re  mpc   n z d ov un
      add(0, 0,0, 8'h00, 9'h1FF, 0,0,0, 0,0, 9'h1FF, 0,0,0, 0,0); // plain jump
      add(0, 1,0, 8'h00, 9'h000, 0,1,0, 0,0, 9'h000, 1,0,0, 0,0); // JAMN, N not latched yet
      add(0, 1,0, 8'h00, 9'h000, 0,1,0, 0,0, 9'h100, 1,0,0, 0,0); // JAMN takes effect
      add(0, 0,0, 8'h00, 9'h000, 0,1,0, 0,0, 9'h100, 0,0,0, 0,0); // old N_q still 1
      add(0, 0,0, 8'h00, 9'h000, 0,1,0, 0,0, 9'h000, 0,0,0, 0,0);
      add(0, 0,1, 8'h55, 9'h0F0, 1,0,1, 0,0, 9'h0F5, 0,1,0, 0,0); // JMPC, Z pending
      add(0, 0,1, 8'h55, 9'h0F0, 1,0,1, 0,0, 9'h1F5, 0,1,0, 0,0); // JMPC + JAMZ
      add(0, 0,0, 8'h55, 9'h0F0, 1,0,1, 0,0, 9'h1F5, 0,0,0, 0,0);
      add(0, 0,0, 8'h55, 9'h0F0, 1,0,1, 0,0, 9'h0F5, 0,0,0, 0,0);
      add(0, 0,0, 8'h00, 9'h010, 0,0,0, 0,0, 9'h010, 0,0,0, 0,0);
      add(0, 0,0, 8'h00, 9'h080, 0,0,0, 1,0, 9'h080, 0,0,1, 0,0); // call, push 011
      add(0, 0,0, 8'h00, 9'h0C0, 0,0,0, 1,0, 9'h0C0, 0,0,2, 0,0); // call, push 081
      add(0, 0,0, 8'hFF, 9'h033, 1,0,0, 0,1, 9'h081, 0,0,1, 0,0); // ret ignores jmpc
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h011, 0,0,0, 0,0);
      add(0, 0,0, 8'h00, 9'h0A0, 0,0,0, 1,0, 9'h0A0, 0,0,1, 0,0); // push 012
      add(0, 0,0, 8'h00, 9'h0A1, 0,0,0, 1,0, 9'h0A1, 0,0,2, 0,0); // push 0A1
      add(0, 0,0, 8'h00, 9'h0A2, 0,0,0, 1,0, 9'h0A2, 0,0,3, 0,0); // push 0A2
      add(0, 0,0, 8'h00, 9'h0A3, 0,0,0, 1,0, 9'h0A3, 0,0,4, 0,0); // push 0A3, full
      add(0, 0,0, 8'h00, 9'h0A4, 0,0,0, 1,0, 9'h0A4, 0,0,4, 1,0); // overflow, branch taken
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h0A3, 0,0,3, 1,0);
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h0A2, 0,0,2, 1,0);
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h0A1, 0,0,1, 1,0);
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h012, 0,0,0, 1,0);
      add(0, 0,0, 8'h00, 9'h1AB, 0,0,0, 0,1, 9'h000, 0,0,0, 1,1); // underflow -> reset addr
      add(0, 0,0, 8'h00, 9'h050, 0,0,0, 1,0, 9'h050, 0,0,1, 1,1); // push 001
      add(0, 0,0, 8'h00, 9'h077, 0,0,0, 1,1, 9'h001, 0,0,0, 1,1); // call+ret: pop only
      add(0, 0,0, 8'h00, 9'h1FF, 0,0,0, 0,0, 9'h1FF, 0,0,0, 1,1);
      add(0, 0,0, 8'h00, 9'h020, 0,0,0, 1,0, 9'h020, 0,0,1, 1,1); // push wraps to 000
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h000, 0,0,0, 1,1);
      add(0, 0,0, 8'h00, 9'h030, 0,0,0, 1,0, 9'h030, 0,0,1, 1,1); // push 001
      add(1, 1,1, 8'hAA, 9'h155, 0,0,0, 0,0, 9'h030, 0,0,1, 1,1); // stalled
      add(1, 0,1, 8'h33, 9'h0AA, 1,0,0, 1,0, 9'h030, 0,0,1, 1,1); // stalled call
      add(1, 1,0, 8'hCC, 9'h1CC, 0,1,0, 0,1, 9'h030, 0,0,1, 1,1); // stalled ret
      add(0, 1,0, 8'h00, 9'h044, 0,0,0, 0,0, 9'h044, 1,0,1, 1,1); // resume
      add(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1, 9'h001, 0,0,0, 1,1);

      drive(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,0);
      rst = 1'b0;
      #12;
      check("reset", 9'h000, 0, 0, 0, 0, 0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].n, vecs[i].z, vecs[i].mbr, vecs[i].na,
               vecs[i].jc, vecs[i].jn, vecs[i].jz, vecs[i].ca, vecs[i].re);
         step();
         check($sformatf("vec%0d", i), vecs[i].e_mpc, vecs[i].e_n, vecs[i].e_z,
               vecs[i].e_depth, vecs[i].e_ovf, vecs[i].e_unf);
      end

      // Build depth 2, then reset asynchronously mid-cycle.
      drive(0, 0,0, 8'h00, 9'h060, 0,0,0, 1,0);
      step();
      check("seq_call1", 9'h060, 0, 0, 1, 1, 1);
      drive(0, 0,0, 8'h00, 9'h070, 0,0,0, 1,0);
      step();
      check("seq_call2", 9'h070, 0, 0, 2, 1, 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 9'h000, 0, 0, 0, 0, 0);
      drive(0, 1,1, 8'hFF, 9'h1FF, 1,1,1, 1,0);
      step();
      check("reset_hold", 9'h000, 0, 0, 0, 0, 0);
      #1;
      rst = 1'b1;
      drive(0, 0,0, 8'h00, 9'h1FF, 0,0,0, 0,0);
      step();
      check("post_reset_jump", 9'h1FF, 0, 0, 0, 0, 0);
      drive(0, 0,0, 8'h00, 9'h000, 0,0,0, 0,1);
      step();
      check("no_stale_ret", 9'h000, 0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mic1_microsequencer.md
Name: mic1_microsequencer

Overview:
- Parametrised next-generation MIC-1 control-path sequencer.
- Holds the microprogram counter (MPC) and the latched ALU flags N/Z, and computes the next microaddress from the MIR fields, the flags and MBR.
- Adds three capabilities: a hardware micro-call/return stack, a stall input, and sticky stack-error reporting.
- Sits between the control store (MIR fields in) and the control-store address port (MPC out).

Parameters:
- ADDR_W, 9, microaddress width (MPC and next_addr).
- MBR_W, 8, MBR width; must be <= ADDR_W-1.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, MPC value after reset and after a return underflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- stall  in  1  1 = freeze all state this cycle.
- N  in  1  ALU negative flag.
- Z  in  1  ALU zero flag.
- MBR  in  MBR_W  opcode byte for multiway branch.
- next_addr  in  ADDR_W  MIR NEXT_ADDRESS field.
- jmpc  in  1  MIR JMPC: OR MBR into the low bits.
- jamn  in  1  MIR JAMN.
- jamz  in  1  MIR JAMZ.
- call  in  1  push MPC+1, then branch.
- ret  in  1  pop the stack into MPC.
- MPC  out  ADDR_W  current microaddress.
- N_q  out  1  latched N.
- Z_q  out  1  latched Z.
- depth  out  clog2(STACK_DEPTH+1)  occupied stack entries.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- ovf  out  1  sticky: call while full.
- unf  out  1  sticky: ret while empty.

Behaviour:
- Reset (rst=0, async): MPC=RESET_ADDR; N_q=Z_q=0; depth=0; stack_empty=1; stack_full=0; ovf=unf=0. All outputs hold these values while rst is low. First update occurs on the first rising edge after rst deasserts.
- All updates occur on the rising edge of clk and only when stall=0. With stall=1, MPC, N_q, Z_q, the stack contents, depth, ovf and unf all hold.
- Flag latch: N_q<=N, Z_q<=Z every unstalled edge.
- Next-address calculation uses the registered N_q/Z_q, so a flag presented in cycle k steers MPC at the edge ending cycle k+1 (two-edge flag latency).
- high_bit = (jamz & Z_q) | (jamn & N_q) | next_addr[ADDR_W-1].
- low = next_addr[ADDR_W-2:0], ORed with the zero-extended MBR when jmpc=1.
- target = {high_bit, low}.
- Priority, evaluated in this order:
  1. ret=1, depth>0: MPC<=top entry; depth-1. The jam, jmpc and call fields are ignored. If call=1 simultaneously, call is dropped and ovf/unf are unchanged.
  2. ret=1, depth==0: MPC<=RESET_ADDR; unf<=1; depth stays 0.
  3. call=1, depth<STACK_DEPTH: push MPC+1 (mod 2^ADDR_W, wraps to 0); depth+1; MPC<=target.
  4. call=1, depth==STACK_DEPTH: no push; ovf<=1; MPC<=target (the branch is still taken).
  5. Otherwise: MPC<=target.
- The stack is LIFO. The top entry is the most recent push. Entries beyond depth are don't-care.
- stack_full and stack_empty are combinational decodes of registered depth.
- ovf and unf are cleared only by reset.
- Reset asserted mid-stack clears depth immediately; stale entries are never returned.

Test Plan:
- Reset then jump: rst low mid-run with depth=2 → MPC=0, depth=0, ovf=unf=0 immediately. Release, next_addr=9'h1FF, all jump controls 0 → MPC=9'h1FF after 1 edge.
- JAMN two-edge latency: N=1, jamn=1, next_addr=0 held two edges → MPC=9'h100. Repeat with N=0 → MPC=9'h000.
- JMPC plus JAMZ: next_addr=9'h0F0, MBR=8'h55, jmpc=1, jamz=1, Z=1 held two edges → MPC=9'h1F5. Same with Z=0 → 9'h0F5.
- Call/return nesting:
  - From MPC=9'h010, call with next_addr=9'h080 → MPC=9'h080, depth=1.
  - Call again from 9'h080 with next_addr=9'h0C0 → MPC=9'h0C0, depth=2.
  - ret → MPC=9'h081; ret → MPC=9'h011; depth=0, stack_empty=1.
- Stack errors: 5 calls with STACK_DEPTH=4 → depth=4, stack_full=1, ovf=1, MPC=last target. Drain 4 rets, then 1 extra ret → MPC=RESET_ADDR, unf=1. Simultaneous call+ret with depth=1 → pop only, depth=0.
- Stall: stall=1 for 3 cycles while next_addr, N and MBR toggle → MPC, N_q, Z_q and depth unchanged. Deassert stall → normal update on the next edge.
